// File: rtl/abcn_reg_pkg.sv
// Shared types and constants for the serial register chain master.
// Ports: none (package: default width, FSM state enum, opcode constants).
package abcn_reg_pkg;

   localparam int DEF_DW = 32;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOADOUT,
      SHIFT,
      LATCH,
      DONE
   } state_e;

endpackage

// File: rtl/reg_shift_counter.sv
// Bit counter for the serial shift phase: clear, count enable, terminal count.
// Ports: bclk/rstb clock and sync active-low reset; clr, en in; cnt, tc out.
module reg_shift_counter #(
   parameter int DW = 32,
   parameter int CW = $clog2(DW)
) (
   input  logic          bclk,
   input  logic          rstb,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc  = (cnt_q == CW'(DW - 1));
   assign cnt = cnt_q;

   // Saturates at DW-1 so it never wraps inside a shift phase.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge bclk) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reg_serial_access.sv
// Command master for the serial-load register chain: turns one parallel
// read/write command into clk_en/shift_en/shift_in/latch_in/latch_out strobes.
// Ports: bclk, rstb; cmd_valid/ready/write/addr/wdata command side;
// rsp_valid/err/rdata response; per-register strobes and shift_out in.
module reg_serial_access
   import abcn_reg_pkg::*;
#(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int DW   = DEF_DW
) (
   input  logic            bclk,
   input  logic            rstb,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [DW-1:0]   cmd_wdata,
   output logic            rsp_valid,
   output logic            rsp_err,
   output logic [DW-1:0]   rsp_rdata,
   output logic [NREG-1:0] clk_en,
   output logic [NREG-1:0] shift_en,
   output logic            shift_in,
   output logic [NREG-1:0] latch_in,
   output logic [NREG-1:0] latch_out,
   input  logic [NREG-1:0] shift_out
);

   localparam int CW = $clog2(DW);

   state_e state_q, state_d;

   logic            write_q, write_d;
   logic            err_q, err_d;
   logic [NREG-1:0] sel_q, sel_d;
   logic [DW-1:0]   sdata_q, sdata_d;
   logic [DW-1:0]   rd_acc_q, rd_acc_d;

   logic            cmd_ready_q, cmd_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [NREG-1:0] clk_en_q, clk_en_d;
   logic [NREG-1:0] shift_en_q, shift_en_d;
   logic            shift_in_q, shift_in_d;
   logic [NREG-1:0] latch_in_q, latch_in_d;
   logic [NREG-1:0] latch_out_q, latch_out_d;

   logic [NREG-1:0] dec;
   logic            accept;
   logic            bit_in;
   logic            cnt_clr;
   logic            cnt_en;
   logic [CW-1:0]   cnt;
   logic            tc;
   logic [CW-1:0]   rd_idx;

   assign accept  = cmd_valid && cmd_ready_q;
   assign bit_in  = |(shift_out & sel_q);
   assign cnt_clr = (state_d == SHIFT) && (state_q != SHIFT);
   assign cnt_en  = (state_q == SHIFT);
   assign rd_idx  = CW'(DW - 1) - cnt;

   reg_shift_counter #(
      .DW (DW),
      .CW (CW)
   ) u_cnt (
      .bclk (bclk),
      .rstb (rstb),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (cnt),
      .tc   (tc)
   );

   // One-hot address decode; an out-of-range address decodes to zero,
   // which gates every strobe for that command.
   always_comb begin
      dec = '0;
      for (int i = 0; i < NREG; i++) begin
         if (cmd_addr == AW'(i)) begin
            dec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      err_d       = err_q;
      sel_d       = sel_q;
      sdata_d     = sdata_q;
      rd_acc_d    = rd_acc_q;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               write_d = cmd_write;
               err_d   = (dec == '0);
               sel_d   = dec;
               sdata_d = cmd_wdata;
               state_d = (cmd_write == OP_WRITE) ? SHIFT : LOADOUT;
            end
         end
         LOADOUT: state_d = SHIFT;
         SHIFT: begin
            if (write_q == OP_WRITE) begin
               sdata_d = {sdata_q[DW-2:0], 1'b0};
            end else begin
               rd_acc_d[rd_idx] = bit_in;
            end
            if (tc) begin
               state_d = (write_q == OP_WRITE) ? LATCH : DONE;
            end
         end
         LATCH: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if ((state_d == DONE) && (state_q != DONE)) begin
         if (err_q) begin
            rsp_rdata_d = '0;
         end else if (write_q == OP_READ) begin
            rsp_rdata_d = rd_acc_d;
         end
      end
   end

   // Outputs are registered from the next state so each strobe lines up
   // with the state it belongs to.
   always_comb begin
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == DONE);
      rsp_err_d   = (state_d == DONE) && err_d;
      clk_en_d    = (state_d != IDLE)    ? sel_d : '0;
      shift_en_d  = (state_d == SHIFT)   ? sel_d : '0;
      latch_in_d  = (state_d == LATCH)   ? sel_d : '0;
      latch_out_d = (state_d == LOADOUT) ? sel_d : '0;
      shift_in_d  = (state_d == SHIFT) && (write_d == OP_WRITE)
                    && !err_d && sdata_d[DW-1];
   end

   always_ff @(posedge bclk) begin
      if (!rstb) begin
         state_q     <= IDLE;
         write_q     <= OP_READ;
         err_q       <= 1'b0;
         sel_q       <= '0;
         sdata_q     <= '0;
         rd_acc_q    <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         clk_en_q    <= '0;
         shift_en_q  <= '0;
         shift_in_q  <= 1'b0;
         latch_in_q  <= '0;
         latch_out_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         err_q       <= err_d;
         sel_q       <= sel_d;
         sdata_q     <= sdata_d;
         rd_acc_q    <= rd_acc_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         clk_en_q    <= clk_en_d;
         shift_en_q  <= shift_en_d;
         shift_in_q  <= shift_in_d;
         latch_in_q  <= latch_in_d;
         latch_out_q <= latch_out_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign clk_en    = clk_en_q;
   assign shift_en  = shift_en_q;
   assign shift_in  = shift_in_q;
   assign latch_in  = latch_in_q;
   assign latch_out = latch_out_q;

endmodule

// File: tb/tb_reg_serial_access.sv
// Randomized bench for reg_serial_access with regSC32-style register models.
// Expected values come from a word-level memory model and latency rules.
module tb_reg_serial_access;

   localparam int NREG = 8;
   localparam int AW   = 4;
   localparam int DW   = 32;

   logic            bclk = 1'b0;
   logic            rstb;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_write;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic            rsp_valid;
   logic            rsp_err;
   logic [DW-1:0]   rsp_rdata;
   logic [NREG-1:0] clk_en;
   logic [NREG-1:0] shift_en;
   logic            shift_in;
   logic [NREG-1:0] latch_in;
   logic [NREG-1:0] latch_out;
   logic [NREG-1:0] shift_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [DW-1:0] mem [NREG];
   logic [DW-1:0] exp_rdata;

   logic [DW-1:0] rm_reg [NREG];
   logic [DW-1:0] rm_sh  [NREG];
   int            cal_cnt [NREG];

   reg_serial_access #(
      .NREG (NREG),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .bclk      (bclk),
      .rstb      (rstb),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .clk_en    (clk_en),
      .shift_en  (shift_en),
      .shift_in  (shift_in),
      .latch_in  (latch_in),
      .latch_out (latch_out),
      .shift_out (shift_out)
   );

   always #5 bclk = ~bclk;

   always @(posedge bclk) cyc <= cyc + 1;

   // regSC32-like register: parallel latch plus MSB-first shifter.
   always @(posedge bclk) begin
      for (int r = 0; r < NREG; r++) begin
         if (cyc < 2) begin
            rm_reg[r]  <= '0;
            rm_sh[r]   <= '0;
            cal_cnt[r] <= 0;
         end else begin
            if (latch_out[r]) begin
               rm_sh[r] <= rm_reg[r];
            end else if (shift_en[r]) begin
               rm_sh[r] <= {rm_sh[r][DW-2:0], shift_in};
            end
            if (latch_in[r]) begin
               rm_reg[r]  <= rm_sh[r];
               cal_cnt[r] <= cal_cnt[r] + 1;
            end
         end
      end
   end

   always_comb begin
      shift_out = '0;
      for (int r = 0; r < NREG; r++) begin
         shift_out[r] = rm_sh[r][DW-1];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit hold,
                          output int t);
      bit            ok_a;
      bit            got;
      int            e, e_rsp, e_li, e_lo;
      int            n_clk, n_sh, n_li, n_lo, bad, bad_si, cal0;
      logic [NREG-1:0] mask;
      logic [DW-1:0] word, rdat, exp_rd;
      logic          rerr;
      ok_a = (a < NREG);
      mask = ok_a ? NREG'(1) << a : '0;
      @(negedge bclk);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      chk("ready_idle", 32'(cmd_ready), 1);
      t = cyc + 1;
      cal0 = ok_a ? cal_cnt[a[2:0]] : 0;
      exp_rd = ok_a ? mem[a[2:0]] : '0;
      got = 0; e_rsp = -1; e_li = -1; e_lo = -1;
      n_clk = 0; n_sh = 0; n_li = 0; n_lo = 0; bad = 0; bad_si = 0;
      word = '0; rdat = '0; rerr = 1'bx;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge bclk);
         if (!hold) cmd_valid = 1'b0;
         cmd_write = 1'($urandom);
         cmd_addr  = AW'($urandom);
         cmd_wdata = $urandom;
         e = cyc + 1;
         if (((clk_en | shift_en | latch_in | latch_out) & ~mask) != '0)
            bad++;
         if ((clk_en & mask) != '0) n_clk++;
         if ((shift_en & mask) != '0) begin
            n_sh++;
            word = {word[DW-2:0], shift_in};
         end else if (shift_in) begin
            bad_si++;
         end
         if (!w && shift_in) bad_si++;
         if ((latch_in & mask) != '0) begin
            n_li++;
            e_li = e;
         end
         if ((latch_out & mask) != '0) begin
            n_lo++;
            e_lo = e;
         end
         if (rsp_valid) begin
            got = 1;
            e_rsp = e;
            rerr = rsp_err;
            rdat = rsp_rdata;
            chk("ready_done", 32'(cmd_ready), 0);
         end
      end
      chk("rsp_latency", 32'(e_rsp - t), 34);
      chk("stray_strobe", 32'(bad), 0);
      chk("rsp_err", 32'(rerr), 32'(!ok_a));
      if (ok_a) begin
         chk("clk_en_cycles", 32'(n_clk), 34);
         chk("shift_cycles", 32'(n_sh), 32);
         if (w) begin
            chk("shift_in_stray", 32'(bad_si), 0);
            chk("shift_word", word, d);
            chk("latch_in_n", 32'(n_li), 1);
            chk("latch_in_t", 32'(e_li - t), 33);
            chk("latch_out_n", 32'(n_lo), 0);
            chk("cal_pulse", 32'(cal_cnt[a[2:0]] - cal0), 1);
            mem[a[2:0]] = d;
         end else begin
            chk("latch_out_n", 32'(n_lo), 1);
            chk("latch_out_t", 32'(e_lo - t), 1);
            chk("latch_in_n", 32'(n_li), 0);
            exp_rdata = exp_rd;
         end
      end else begin
         exp_rdata = '0;
      end
      chk("rsp_rdata", rdat, exp_rdata);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready), 1);
      chk({tag, "_rspv"}, 32'(rsp_valid), 0);
      chk({tag, "_rsperr"}, 32'(rsp_err), 0);
      chk({tag, "_rdata"}, rsp_rdata, 0);
      chk({tag, "_strb"}, {clk_en, shift_en, latch_in, latch_out}, 0);
      chk({tag, "_sin"}, 32'(shift_in), 0);
   endtask

   initial begin
      int t0, t1, t2, tr, c0, nb;
      logic [AW-1:0] ra;
      bit rw;
      rstb = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      exp_rdata = '0;
      for (int r = 0; r < NREG; r++) mem[r] = '0;
      repeat (4) @(negedge bclk);
      reset_check("rst");
      rstb = 1'b1;

      run_cmd(1, 4'd0, 32'h0000_0001, 0, t0);
      run_cmd(1, 4'd3, 32'hA5C3_0F81, 0, t0);
      run_cmd(0, 4'd3, 32'h0, 0, t0);
      run_cmd(0, 4'd9, 32'h0, 0, t0);
      run_cmd(1, 4'd9, 32'h1234_5678, 0, t0);

      run_cmd(1, 4'd1, $urandom, 1, t0);
      run_cmd(1, 4'd2, $urandom, 1, t1);
      run_cmd(1, 4'd6, $urandom, 1, t2);
      cmd_valid = 1'b0;
      chk("b2b_gap1", 32'(t1 - t0), 35);
      chk("b2b_gap2", 32'(t2 - t1), 35);

      @(negedge bclk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 4'd2;
      cmd_wdata = $urandom;
      tr = cyc + 1;
      c0 = cal_cnt[2];
      @(negedge bclk);
      cmd_valid = 1'b0;
      repeat (10) @(negedge bclk);
      chk("rst_k10_pos", 32'(cyc + 1 - tr), 11);
      chk("rst_k10_shift", 32'(shift_en[2]), 1);
      rstb = 1'b0;
      @(negedge bclk);
      rstb = 1'b1;
      exp_rdata = '0;
      reset_check("midrst");
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge bclk);
         if ((clk_en | shift_en | latch_in | latch_out) != '0 || rsp_valid)
            nb++;
      end
      chk("midrst_quiet", 32'(nb), 0);
      chk("midrst_cal", 32'(cal_cnt[2] - c0), 0);

      run_cmd(1, 4'd5, 32'hFFFF_FFFF, 0, t0);
      run_cmd(0, 4'd5, 32'h0, 0, t0);
      run_cmd(0, 4'd2, 32'h0, 0, t0);

      for (int n = 0; n < 24; n++) begin
         rw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) ra = AW'($urandom_range(8, 15));
         else ra = AW'($urandom_range(0, 7));
         run_cmd(rw, ra, $urandom, 0, t0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
